// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide pipeline interface: MD operation
// encoding, class helpers and the default unit latencies (also used by E_HILO).
package md_pkg;

  typedef logic [3:0] md_type_t;

  localparam md_type_t MD_NONE = 4'd0;
  localparam md_type_t MULT    = 4'd1;
  localparam md_type_t MULTU   = 4'd2;
  localparam md_type_t DIV     = 4'd3;
  localparam md_type_t DIVU    = 4'd4;
  localparam md_type_t MTHI    = 4'd5;
  localparam md_type_t MTLO    = 4'd6;
  localparam md_type_t MFHI    = 4'd7;
  localparam md_type_t MFLO    = 4'd8;

  // Busy cycles that follow a Start, shared with E_HILO.
  localparam int unsigned MD_MULT_CYCLES = 5;
  localparam int unsigned MD_DIV_CYCLES  = 10;

  // Any instruction that touches HI/LO.
  function automatic logic is_md(input md_type_t x);
    return (x >= MULT) && (x <= MFLO);
  endfunction

  // Instructions that start a multi-cycle operation in E_HILO.
  function automatic logic is_mul_div(input md_type_t x);
    return (x >= MULT) && (x <= DIVU);
  endfunction

  // Two-state view of the shadow latency tracker.
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

endpackage

// File: rtl/md_shadow_counter.sv
// Shadow latency counter: mirrors how long E_HILO should report Busy after a
// mul/div issues in E. Loads on an expected Start, counts down to zero.
module md_shadow_counter
  import md_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES,
  parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] e_md_type,
  output logic       exp_start,
  output logic [3:0] cnt,
  output logic       busy
);

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

  logic [0:0] state_reg, state_next;
  logic [3:0] cnt_reg, cnt_next;

  // A mul/div in E only issues when nothing is outstanding; while BUSY a
  // second one is a stall violation and must not reload the counter.
  assign exp_start = is_mul_div(e_md_type) && (state_reg == S_IDLE);

  // Next-state: load on issue, decrement while busy, go idle on 1 -> 0.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      S_IDLE: begin
        if (exp_start) begin
          cnt_next   = ((e_md_type == MULT) || (e_md_type == MULTU)) ? MULT_LOAD : DIV_LOAD;
          state_next = (cnt_next != 4'd0) ? S_BUSY : S_IDLE;
        end
      end
      default: begin
        cnt_next = cnt_reg - 4'd1;
        if (cnt_reg == 4'd1) begin
          state_next = S_IDLE;
        end
      end
    endcase
  end

  // State and count registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_IDLE;
      cnt_reg   <= 4'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  assign cnt  = cnt_reg;
  assign busy = (state_reg == S_BUSY);

endmodule

// File: rtl/md_stall_ctrl.sv
// Initiator side of the E_HILO handshake: D-stage stall decision, shadow
// latency tracking with protocol cross-check, and a stall-cycle counter.
module md_stall_ctrl
  import md_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES,
  parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES,
  parameter bit          CHECK_EN    = 1'b1,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       D_MDType,
  input  logic [3:0]       E_MDType,
  input  logic             HILO_Start,
  input  logic             HILO_Busy,
  output logic             StallD,
  output logic             ShadowBusy,
  output logic [3:0]       ShadowCnt,
  output logic             ProtoErr,
  output logic [CNT_W-1:0] StallCnt
);

  logic             exp_start;
  logic [CNT_W-1:0] stall_cnt_reg;

  md_shadow_counter #(
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_shadow (
    .clk      (clk),
    .reset    (reset),
    .e_md_type(E_MDType),
    .exp_start(exp_start),
    .cnt      (ShadowCnt),
    .busy     (ShadowBusy)
  );

  // The shadow term keeps the pipeline safe even if E_HILO under-reports Busy.
  assign StallD = is_md(D_MDType) && (HILO_Start || HILO_Busy || ShadowBusy);

  // Saturating count of MD-induced stall cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_reg <= '0;
    end else if (StallD && (stall_cnt_reg != {CNT_W{1'b1}})) begin
      stall_cnt_reg <= stall_cnt_reg + 1'b1;
    end
  end

  assign StallCnt = stall_cnt_reg;

  generate
    if (CHECK_EN) begin : g_check
      logic err_reg;
      logic mismatch;

      assign mismatch = (HILO_Start != exp_start) ||
                        (HILO_Busy != ShadowBusy) ||
                        (is_md(E_MDType) && ShadowBusy);

      // Sticky error: once a handshake mismatch is seen it holds until reset.
      always_ff @(posedge clk) begin
        if (reset) begin
          err_reg <= 1'b0;
        end else if (mismatch) begin
          err_reg <= 1'b1;
        end
      end

      // Flag is visible in the offending cycle itself, not a cycle later.
      assign ProtoErr = err_reg || (mismatch && !reset);
    end else begin : g_nocheck
      assign ProtoErr = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_md_stall_ctrl.sv
// Self-checking bench for md_stall_ctrl: directed handshake scenarios plus a
// randomized pipeline with an ideal E_HILO responder and injected faults.
module tb_md_stall_ctrl;

  localparam logic [3:0] T_MULT = 4'd1;
  localparam logic [3:0] T_DIV  = 4'd3;
  localparam logic [3:0] T_MTHI = 4'd5;
  localparam logic [3:0] T_MFHI = 4'd7;
  localparam logic [3:0] T_MFLO = 4'd8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic [3:0] d_md = 4'd0;
  logic [3:0] e_md = 4'd0;
  logic       start = 1'b0;
  logic       busy = 1'b0;

  logic        stall, sbusy, perr;
  logic [3:0]  scnt;
  logic [31:0] stall_cnt;
  logic        stall4, sbusy4, perr4;
  logic [3:0]  scnt4;
  logic [3:0]  stall_cnt4;

  md_stall_ctrl dut (
    .clk(clk), .reset(reset), .D_MDType(d_md), .E_MDType(e_md),
    .HILO_Start(start), .HILO_Busy(busy), .StallD(stall), .ShadowBusy(sbusy),
    .ShadowCnt(scnt), .ProtoErr(perr), .StallCnt(stall_cnt)
  );

  md_stall_ctrl #(.CNT_W(4)) dut_sat (
    .clk(clk), .reset(reset), .D_MDType(d_md), .E_MDType(e_md),
    .HILO_Start(start), .HILO_Busy(busy), .StallD(stall4), .ShadowBusy(sbusy4),
    .ShadowCnt(scnt4), .ProtoErr(perr4), .StallCnt(stall_cnt4)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_on   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic bit ismd(input logic [3:0] x);
    return (x >= 1) && (x <= 8);
  endfunction

  function automatic bit ismuldiv(input logic [3:0] x);
    return (x >= 1) && (x <= 4);
  endfunction

  // Reference model: remaining latency, sticky error, stall counts.
  int     m_rem = 0;
  bit     m_err = 1'b0;
  longint m_sc  = 0;
  int     m_sc4 = 0;

  function automatic bit model_mismatch();
    bit ebusy;
    bit estart;
    ebusy  = (m_rem > 0);
    estart = ismuldiv(e_md) && (m_rem == 0);
    return (start !== estart) || (busy !== ebusy) || (ismd(e_md) && ebusy);
  endfunction

  function automatic bit model_stall();
    return ismd(d_md) && (start || busy || (m_rem > 0));
  endfunction

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      check("stall_d", stall, model_stall());
      check("stall_d_w4", stall4, model_stall());
      check("shadow_cnt", scnt, m_rem);
      check("shadow_busy", sbusy, m_rem > 0);
      check("proto_err", perr, m_err || (!reset && model_mismatch()));
      check("stall_cnt", stall_cnt, m_sc);
      check("stall_cnt_w4", stall_cnt4, m_sc4);
    end
  end

  // Model state advance on each rising edge (inputs change only at +1).
  always @(posedge clk) begin
    if (reset) begin
      m_rem = 0; m_err = 1'b0; m_sc = 0; m_sc4 = 0;
    end else begin
      if (model_mismatch()) m_err = 1'b1;
      if (model_stall()) begin
        if (m_sc < 64'hFFFF_FFFF) m_sc = m_sc + 1;
        if (m_sc4 < 15) m_sc4 = m_sc4 + 1;
      end
      if (m_rem > 0) m_rem = m_rem - 1;
      else if (ismuldiv(e_md)) m_rem = (e_md <= 4'd2) ? 5 : 10;
    end
  end

  // One clock cycle: apply inputs just after the edge, return mid-cycle.
  task automatic cyc(input logic r, input logic [3:0] d, input logic [3:0] e,
                     input logic s, input logic b);
    @(posedge clk);
    #1;
    reset = r; d_md = d; e_md = e; start = s; busy = b;
    @(negedge clk);
  endtask

  task automatic do_reset();
    cyc(1'b1, 4'd0, 4'd0, 1'b0, 1'b0);
    cyc(1'b1, 4'd0, 4'd0, 1'b0, 1'b0);
  endtask

  initial begin
    int base;
    int hilo_rem;
    bit prev_stall;
    logic [3:0] dcur, e;
    logic r, s, b;

    do_reset();
    chk_on = 1'b1;

    // Reset state
    cyc(1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
    check("rst_shadow_cnt", scnt, 0);
    check("rst_shadow_busy", sbusy, 0);
    check("rst_proto_err", perr, 0);
    check("rst_stall_cnt", stall_cnt, 0);
    $display("txn reset: cnt=%0d busy=%0d err=%0d stalls=%0d", scnt, sbusy, perr, stall_cnt);

    // Mult then mfhi
    cyc(1'b0, T_MFHI, T_MULT, 1'b1, 1'b0);
    check("mul_stall_c0", stall, 1);
    for (int k = 1; k <= 5; k++) begin
      cyc(1'b0, T_MFHI, 4'd0, 1'b0, 1'b1);
      check("mul_stall_busy", stall, 1);
      check("mul_shadow_cnt", scnt, 6 - k);
    end
    cyc(1'b0, T_MFHI, 4'd0, 1'b0, 1'b0);
    check("mul_release", stall, 0);
    check("mul_stall_cnt", stall_cnt, 6);
    check("mul_proto_err", perr, 0);
    $display("txn mult+mfhi: stalls=%0d err=%0d", stall_cnt, perr);
    cyc(1'b0, 4'd0, T_MFHI, 1'b0, 1'b0);

    // Div latency with a non-MD instruction in D
    base = int'(stall_cnt);
    cyc(1'b0, 4'd0, T_DIV, 1'b1, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      cyc(1'b0, 4'd0, 4'd0, 1'b0, 1'b1);
      check("div_shadow_cnt", scnt, 11 - k);
      check("div_no_stall", stall, 0);
    end
    cyc(1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
    check("div_cnt_zero", scnt, 0);
    check("div_busy_fall", sbusy, 0);
    check("div_stall_cnt_same", stall_cnt, base);
    $display("txn div: cnt=%0d busy=%0d stalls=%0d", scnt, sbusy, stall_cnt);

    // Handshake fault: Busy dropped after 4 cycles
    do_reset();
    cyc(1'b0, T_MFHI, T_MULT, 1'b1, 1'b0);
    for (int k = 1; k <= 4; k++) cyc(1'b0, T_MFHI, 4'd0, 1'b0, 1'b1);
    cyc(1'b0, T_MFHI, 4'd0, 1'b0, 1'b0);
    check("drop_proto_err", perr, 1);
    check("drop_stall_shadow", stall, 1);
    $display("txn busy-drop: err=%0d stall=%0d", perr, stall);
    cyc(1'b0, T_MFHI, 4'd0, 1'b0, 1'b0);

    // Handshake fault: spurious Start with MTHI
    do_reset();
    cyc(1'b0, 4'd0, T_MTHI, 1'b1, 1'b0);
    check("spurious_start_err", perr, 1);
    $display("txn spurious-start: err=%0d", perr);

    // Reset mid-divide
    do_reset();
    cyc(1'b0, T_MFLO, T_DIV, 1'b1, 1'b0);
    for (int k = 1; k <= 4; k++) cyc(1'b0, T_MFLO, 4'd0, 1'b0, 1'b1);
    cyc(1'b1, T_MFLO, 4'd0, 1'b0, 1'b1);
    check("mid_rst_cnt_before", scnt, 6);
    cyc(1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
    check("mid_rst_cnt", scnt, 0);
    check("mid_rst_err", perr, 0);
    check("mid_rst_stall_cnt", stall_cnt, 0);
    cyc(1'b0, 4'd0, T_MULT, 1'b1, 1'b0);
    cyc(1'b0, 4'd0, 4'd0, 1'b0, 1'b1);
    check("post_rst_mult_cnt", scnt, 5);
    check("post_rst_mult_err", perr, 0);
    for (int k = 2; k <= 5; k++) cyc(1'b0, 4'd0, 4'd0, 1'b0, 1'b1);
    cyc(1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
    $display("txn reset-mid-div: cnt=%0d err=%0d", scnt, perr);

    // Saturation of the narrow counter
    do_reset();
    repeat (20) cyc(1'b0, T_MFHI, 4'd0, 1'b0, 1'b1);
    cyc(1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
    check("sat_w4", stall_cnt4, 15);
    check("sat_w32", stall_cnt, 20);
    $display("txn saturation: w4=%0d w32=%0d", stall_cnt4, stall_cnt);
    do_reset();

    // Randomized pipeline with an ideal E_HILO and occasional faults/resets
    hilo_rem = 0; prev_stall = 1'b0; dcur = 4'd0;
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 299) == 0);
      if (!prev_stall) begin
        e = dcur;
        dcur = 4'($urandom_range(0, 15));
      end else begin
        e = 4'd0;
      end
      s = ismuldiv(e) && (hilo_rem == 0);
      b = (hilo_rem > 0);
      if ($urandom_range(0, 199) == 0) s = ~s;
      if ($urandom_range(0, 199) == 0) b = ~b;
      cyc(r, dcur, e, s, b);
      prev_stall = stall;
      if (r) hilo_rem = 0;
      else if (hilo_rem > 0) hilo_rem--;
      else if (ismuldiv(e)) hilo_rem = (e <= 4'd2) ? 5 : 10;
      if ((i % 500) == 0)
        $display("txn random %0d: d=%0d e=%0d stall=%0d cnt=%0d err=%0d", i, dcur, e, stall, scnt, perr);
    end

    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
